// File: rtl/uart_tx_driver.sv
// ============================================================================
//  Module      : uart_tx_driver
//  Description : Buffered UART transmitter (8N1, or 8E1 when UART_TX_PARITY_EN
//                is defined). Bytes queue in a small FIFO and are serialized
//                LSB-first at CLKS_PER_BIT clocks per bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_driver #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int AW           = 2
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic [7:0] wdata,
    input  logic       wr,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       overflow,
    output logic       tx
);

    localparam int             c_BW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BW-1:0] c_BAUD_MAX = c_BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]    c_DEPTH    = (AW+1)'(FIFO_DEPTH);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_PARITY = 3'd4;
`endif

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic            r_overflow;

    logic [2:0]      r_state;
    logic [c_BW-1:0] r_baud;
    logic [2:0]      r_bitcnt;
    logic [7:0]      r_shift;
    logic            r_tx;
`ifdef UART_TX_PARITY_EN
    logic            r_parity;
`endif

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_bit_end;
    logic [7:0]      w_head;

    always_comb begin
        w_full    = (r_count == c_DEPTH);
        w_empty   = (r_count == '0);
        w_push    = wr && !w_full;
        w_bit_end = (r_baud == c_BAUD_MAX);
        // Pops happen from IDLE, or back-to-back at the last cycle of STOP.
        w_pop     = !w_empty && ((r_state == c_IDLE) ||
                                 ((r_state == c_STOP) && w_bit_end));
        w_head    = r_mem[r_rptr];
    end

    always_ff @(posedge HCLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= wr && w_full;
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // r_tx is loaded with the level of the state being entered, so the line
    // changes on the same edge as the state register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state  <= c_IDLE;
            r_baud   <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_baud <= '0;
                    if (w_pop) begin
                        r_state  <= c_START;
                        r_tx     <= 1'b0;
                        r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^w_head;
`endif
                    end
                end
                c_START: begin
                    if (w_bit_end) begin
                        r_baud   <= '0;
                        r_bitcnt <= '0;
                        r_state  <= c_DATA;
                        r_tx     <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + c_BW'(1);
                    end
                end
                c_DATA: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_shift <= r_shift >> 1;
                        if (r_bitcnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= c_PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= c_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                            r_tx     <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + c_BW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                c_PARITY: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_state <= c_STOP;
                        r_tx    <= 1'b1;
                    end else begin
                        r_baud <= r_baud + c_BW'(1);
                    end
                end
`endif
                c_STOP: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_state  <= c_START;
                            r_tx     <= 1'b0;
                            r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
                            r_parity <= ^w_head;
`endif
                        end else begin
                            r_state <= c_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + c_BW'(1);
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_baud  <= '0;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign full     = w_full;
    assign empty    = w_empty;
    assign busy     = (r_state != c_IDLE);
    assign overflow = r_overflow;
    assign tx       = r_tx;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_driver.sv
// ============================================================================
//  Module      : tb_uart_tx_driver
//  Description : Self-checking bench for uart_tx_driver (directed vectors).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_driver;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int CPB = 16;
    localparam int FL  = NB * CPB;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic [7:0] wdata;
    logic       wr;
    logic       full, empty, busy, overflow, tx;

    int cyc     = 0;
    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    vec_t tbl [7];

    logic [7:0] m2 [4] = '{8'h48, 8'h69, 8'h21, 8'h0A};
    logic       p2 [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] m3 [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    logic       p3 [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] m5 [6] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
    logic       p5 [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    logic mon_full_en = 1'b0;
    int   full_seen   = 0;

    uart_tx_driver #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4),
        .AW           (2)
    ) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .wdata    (wdata),
        .wr       (wr),
        .full     (full),
        .empty    (empty),
        .busy     (busy),
        .overflow (overflow),
        .tx       (tx)
    );

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc++;
    always @(negedge HCLK) if (mon_full_en && full) full_seen++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        else
            n_pass++;
    endtask

    // Returns at the falling edge following rising edge number t.
    task automatic at_cyc(input int t);
        while (cyc < t) @(negedge HCLK);
    endtask

    task automatic check_frame(input logic [7:0] b, input logic par, input int s);
        logic e;
        for (int i = 0; i < NB; i++) begin
            at_cyc(s + CPB/2 + CPB*i);
            if (i == 0)           e = 1'b0;
            else if (i <= 8)      e = b[i-1];
            else if (i == NB - 1) e = 1'b1;
            else                  e = par;
            chk($sformatf("tx_bit%0d_of_%02h", i, b), tx, e);
            chk($sformatf("busy_bit%0d_of_%02h", i, b), busy, 1'b1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int viol;

        tbl[0] = '{8'h41, 1'b0};
        tbl[1] = '{8'h07, 1'b1};
        tbl[2] = '{8'h03, 1'b0};
        tbl[3] = '{8'h00, 1'b0};
        tbl[4] = '{8'hFF, 1'b0};
        tbl[5] = '{8'hA5, 1'b0};
        tbl[6] = '{8'h80, 1'b1};

        HRESET = 1'b1;
        wr     = 1'b0;
        wdata  = 8'h00;
        repeat (3) @(negedge HCLK);
        chk("reset_tx", tx, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_full", full, 1'b0);
        chk("reset_empty", empty, 1'b1);
        chk("reset_overflow", overflow, 1'b0);
        HRESET = 1'b0;
        @(negedge HCLK);

        // Single-byte frames from idle, including latency and frame end.
        for (int k = 0; k < 7; k++) begin
            wdata = tbl[k].data;
            wr    = 1'b1;
            n     = cyc + 1;
            @(negedge HCLK);
            wr = 1'b0;
            chk("lat_tx_before_pop", tx, 1'b1);
            chk("lat_busy_before_pop", busy, 1'b0);
            chk("lat_empty_before_pop", empty, 1'b0);
            at_cyc(n + 1);
            chk("lat_tx_start", tx, 1'b0);
            chk("lat_busy_start", busy, 1'b1);
            chk("lat_empty_after_pop", empty, 1'b1);
            check_frame(tbl[k].data, tbl[k].par, n + 1);
            at_cyc(n + FL);
            chk("frame_busy_last_cycle", busy, 1'b1);
            at_cyc(n + 1 + FL);
            chk("frame_busy_done", busy, 1'b0);
            chk("frame_tx_idle", tx, 1'b1);
            at_cyc(n + FL + 4);
        end

        // Back-to-back burst of four bytes: no gap, never full.
        mon_full_en = 1'b1;
        full_seen   = 0;
        n = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            wdata = m2[k];
            wr    = 1'b1;
            @(negedge HCLK);
        end
        wr = 1'b0;
        for (int k = 0; k < 4; k++) check_frame(m2[k], p2[k], n + 1 + FL*k);
        at_cyc(n + 4*FL);
        chk("burst_busy_last", busy, 1'b1);
        at_cyc(n + 1 + 4*FL);
        chk("burst_busy_done", busy, 1'b0);
        mon_full_en = 1'b0;
        chk("burst_full_never", full_seen, 0);
        at_cyc(n + 4*FL + 4);

        // Six writes: fill, one drop; then a write rejected on the pop cycle.
        n = cyc + 1;
        for (int k = 0; k < 6; k++) begin
            wdata = (k < 5) ? m3[k] : 8'h15;
            wr    = 1'b1;
            @(negedge HCLK);
        end
        wr = 1'b0;
        chk("ovf_pulse", overflow, 1'b1);
        chk("ovf_full", full, 1'b1);
        @(negedge HCLK);
        chk("ovf_pulse_end", overflow, 1'b0);
        chk("ovf_full_held", full, 1'b1);
        check_frame(m3[0], p3[0], n + 1);
        at_cyc(n + FL);
        wdata = 8'h55;
        wr    = 1'b1;
        at_cyc(n + FL + 1);
        wr = 1'b0;
        chk("ovf_on_pop_pulse", overflow, 1'b1);
        chk("ovf_on_pop_full", full, 1'b0);
        @(negedge HCLK);
        chk("ovf_on_pop_end", overflow, 1'b0);
        for (int k = 1; k < 5; k++) check_frame(m3[k], p3[k], n + 1 + FL*k);
        at_cyc(n + 1 + 5*FL);
        chk("ovf_drain_busy", busy, 1'b0);
        chk("ovf_drain_empty", empty, 1'b1);
        at_cyc(n + 5*FL + 4);

        // Reset mid-frame with a second byte queued.
        n = cyc + 1;
        wdata = 8'hFF; wr = 1'b1; @(negedge HCLK);
        wdata = 8'hEE; @(negedge HCLK);
        wr = 1'b0;
        at_cyc(n + 50);
        HRESET = 1'b1;
        at_cyc(n + 51);
        HRESET = 1'b0;
        chk("midrst_tx", tx, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_empty", empty, 1'b1);
        chk("midrst_full", full, 1'b0);
        viol = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge HCLK);
            if (tx !== 1'b1 || busy !== 1'b0) viol++;
        end
        chk("midrst_no_frame", viol, 0);

        // Write and pop together at end of STOP with two bytes queued.
        n = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            wdata = m5[k];
            wr    = 1'b1;
            @(negedge HCLK);
        end
        wr = 1'b0;
        check_frame(m5[0], p5[0], n + 1);
        at_cyc(n + FL);
        wdata = m5[3];
        wr    = 1'b1;
        at_cyc(n + FL + 1);
        chk("simul_empty", empty, 1'b0);
        chk("simul_full", full, 1'b0);
        wdata = m5[4];
        @(negedge HCLK);
        chk("simul_count3_full", full, 1'b0);
        wdata = m5[5];
        @(negedge HCLK);
        wr = 1'b0;
        chk("simul_count4_full", full, 1'b1);
        chk("simul_no_overflow", overflow, 1'b0);
        for (int k = 1; k < 6; k++) check_frame(m5[k], p5[k], n + 1 + FL*k);
        at_cyc(n + 1 + 6*FL);
        chk("simul_drain_busy", busy, 1'b0);
        chk("simul_drain_empty", empty, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
